// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: serves 16-bit instructions to the execute stage
// from a small halfword FIFO that is refilled by word-wide memory reads.
module ifetch_queue #(
  parameter int RV    = 32,
  parameter int VA    = RV,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VA-2:0]      pc,
  input  logic               ifetch,
  output logic               idone,
  output logic [15:0]        insn,
  input  logic               flush,
  output logic               mem_req,
  output logic [VA-RV/16-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [RV-1:0]      mem_rdata
);

  localparam int HW = RV / 16;               // halfwords per memory word
  localparam int WB = (HW == 2) ? 1 : 0;     // halfword-in-word address bits
  localparam int HA = VA - 1;                // halfword address width
  localparam int AW = VA - HW;               // word address width
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state, state_nx;
  logic [HA-1:0]   q_head;
  logic            head_valid;
  logic [CW-1:0]   count, count_nx, push_n;
  logic [AW-1:0]   f_addr, req_addr;
  logic            f_skip;
  logic [15:0]     q_mem [DEPTH];
  logic [IW-1:0]   tail;

  logic match, hit, redirect, kill, can_issue, take;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    match     = head_valid && (pc == q_head);
    // The !idone term keeps the still-high ifetch of the pulse cycle inert.
    hit       = ifetch && !idone && !flush && match && (count != '0);
    redirect  = ifetch && !idone && !flush && !match;
    kill      = redirect || flush;
    can_issue = (state == IDLE) && head_valid && !kill &&
                (int'(count) + HW <= DEPTH);
    take      = mem_ack && (can_issue || (state == REQ && !kill));
    push_n    = f_skip ? CW'(1) : CW'(HW);
    count_nx  = count - CW'(hit) + (take ? push_n : '0);
    tail      = q_head[IW-1:0] + count[IW-1:0];

    // IDLE presents the request in the same cycle it is decided, so a
    // redirect reaches memory one cycle later; REQ/DROP hold it until ack.
    mem_req   = can_issue || (state == REQ) || (state == DROP);
    mem_addr  = (state == IDLE) ? f_addr : req_addr;

    state_nx = state;
    case (state)
      IDLE: if (can_issue && !mem_ack) state_nx = REQ;
      REQ:  if (mem_ack) state_nx = IDLE;
            else if (kill) state_nx = DROP;
      DROP: if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      q_head     <= '0;
      head_valid <= 1'b0;
      count      <= '0;
      f_addr     <= '0;
      f_skip     <= 1'b0;
      req_addr   <= '0;
      idone      <= 1'b0;
      insn       <= '0;
    end else begin
      state <= state_nx;
      idone <= hit;
      if (hit) insn <= q_mem[q_head[IW-1:0]];
      if (can_issue) req_addr <= f_addr;

      if (flush) begin
        head_valid <= 1'b0;
        count      <= '0;
      end else if (redirect) begin
        head_valid <= 1'b1;
        q_head     <= pc;
        count      <= '0;
        f_addr     <= AW'(pc >> WB);
        f_skip     <= (HW == 2) ? pc[0] : 1'b0;
      end else begin
        if (hit) q_head <= q_head + HA'(1);
        count <= count_nx;
        if (take) begin
          f_addr <= f_addr + AW'(1);
          f_skip <= 1'b0;
        end
      end
    end
  end

  // NOTE: queue storage is not reset; count and head_valid gate every read.
  always_ff @(posedge clk) begin
    if (take) begin
      if (f_skip) begin
        q_mem[tail] <= mem_rdata[RV-1 -: 16];
      end else begin
        for (int i = 0; i < HW; i++) q_mem[tail + IW'(i)] <= mem_rdata[16*i +: 16];
      end
    end
  end

endmodule
